// File: rtl/core101_issue_pkg.sv
// Shared constants and helpers for the in-order issue stage.
// Latency: none (constants and a pure function).
// Backpressure: not applicable.
package core101_issue_pkg;

    // Execution unit indices; bit i of a select field targets unit i.
    localparam int INT_UNIT = 0;
    localparam int BRU_UNIT = 1;
    localparam int LSU_UNIT = 2;
    localparam int VEC_UNIT = 3;

    // One-hot select values matching the unit indices above.
    localparam logic [3:0] INT_SEL = 4'b0001;
    localparam logic [3:0] BRU_SEL = 4'b0010;
    localparam logic [3:0] LSU_SEL = 4'b0100;
    localparam logic [3:0] VEC_SEL = 4'b1000;

    // Widest select field the one-hot helper accepts; narrower fields are zero-extended.
    localparam int SEL_MAX_W = 32;

    // True when exactly one bit of v is set.
    function automatic logic is_onehot(input logic [SEL_MAX_W-1:0] v);
        return (v != '0) && ((v & (v - SEL_MAX_W'(1))) == '0);
    endfunction

endpackage

// File: rtl/issue_fifo.sv
// Generic synchronous FIFO with flush; storage is not reset, only pointers/count.
// Latency: a write becomes readable at rd_dat the cycle after it is accepted (no bypass).
// Backpressure: writes ignored when full, reads ignored when empty; flush overrides both.
module issue_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clock_in,
    input  logic                       reset_n_in,
    input  logic                       flush,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_dat,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_dat,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign empty  = (count == '0);
    assign full   = (count == CNT_W'(DEPTH));
    assign do_wr  = wr_en && !full && !flush;
    assign do_rd  = rd_en && !empty && !flush;
    assign rd_dat = mem[rd_ptr];

    // Storage write; contents are only ever observed through count-gated logic.
    always_ff @(posedge clock_in) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/issue_queue.sv
// In-order issue stage: buffers decoded uops and steers the head to one one-hot-selected unit.
// Latency: push in cycle N is offered to its unit in cycle N+1 at the earliest; 1 issue/cycle.
// Backpressure: push_ready_out = not full (independent of unit_ready_in); a stalled head blocks all.
module issue_queue
    import core101_issue_pkg::*;
#(
    parameter int NUM_UNITS = 4,
    parameter int DEPTH     = 4,
    parameter int UOP_W     = 4,
    parameter int PAYLOAD_W = 32
) (
    input  logic                         clock_in,
    input  logic                         reset_n_in,
    input  logic                         flush_in,
    input  logic                         push_valid_in,
    output logic                         push_ready_out,
    input  logic [NUM_UNITS-1:0]         exec_unit_sel_in,
    input  logic [UOP_W-1:0]             exec_uop_in,
    input  logic [PAYLOAD_W-1:0]         payload_in,
    output logic                         illegal_sel_out,
    output logic [NUM_UNITS-1:0]         unit_valid_out,
    input  logic [NUM_UNITS-1:0]         unit_ready_in,
    output logic [NUM_UNITS*UOP_W-1:0]   unit_uop_out,
    output logic [PAYLOAD_W-1:0]         unit_payload_out,
    output logic [$clog2(DEPTH+1)-1:0]   count_out
);

    typedef struct packed {
        logic [NUM_UNITS-1:0] sel;
        logic [UOP_W-1:0]     uop;
        logic [PAYLOAD_W-1:0] payload;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    entry_t push_entry;
    entry_t head;
    logic   sel_legal;
    logic   push_hs;
    logic   push_accept;
    logic   pop;
    logic   fifo_empty;
    logic   fifo_full;

    assign push_entry = '{sel: exec_unit_sel_in, uop: exec_uop_in, payload: payload_in};

    // A handshake completes whenever there is room; illegal entries are consumed but dropped.
    assign sel_legal      = is_onehot(SEL_MAX_W'(exec_unit_sel_in));
    assign push_ready_out = !fifo_full;
    assign push_hs        = push_valid_in && push_ready_out;
    assign push_accept    = push_hs && sel_legal && !flush_in;

    // Head retires as soon as its selected unit accepts it.
    assign pop = |(unit_valid_out & unit_ready_in);

    issue_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock_in   (clock_in),
        .reset_n_in (reset_n_in),
        .flush      (flush_in),
        .wr_en      (push_accept),
        .wr_dat     (push_entry),
        .rd_en      (pop),
        .rd_dat     (head),
        .count      (count_out),
        .empty      (fifo_empty),
        .full       (fifo_full)
    );

    // One-cycle rejection pulse; a flush in the offering cycle suppresses it.
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            illegal_sel_out <= 1'b0;
        end else begin
            illegal_sel_out <= push_hs && !sel_legal && !flush_in;
        end
    end

    // Steer the head to its unit; everything is zero while empty so stale storage never leaks.
    always_comb begin
        unit_valid_out   = '0;
        unit_uop_out     = '0;
        unit_payload_out = '0;
        if (!fifo_empty) begin
            unit_valid_out   = head.sel;
            unit_payload_out = head.payload;
            for (int i = 0; i < NUM_UNITS; i++) begin
                if (head.sel[i]) begin
                    unit_uop_out[i*UOP_W +: UOP_W] = head.uop;
                end
            end
        end
    end

endmodule

// File: tb/tb_issue_queue.sv
module tb_issue_queue;
    import core101_issue_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        push_vld;
    logic        push_rdy;
    logic [3:0]  sel;
    logic [3:0]  uop;
    logic [31:0] pay;
    logic        ill;
    logic [3:0]  u_vld;
    logic [3:0]  u_rdy;
    logic [15:0] u_uop;
    logic [31:0] u_pay;
    logic [2:0]  cnt;

    int checks = 0;
    int errors = 0;

    issue_queue dut (
        .clock_in         (clk),
        .reset_n_in       (rst_n),
        .flush_in         (flush),
        .push_valid_in    (push_vld),
        .push_ready_out   (push_rdy),
        .exec_unit_sel_in (sel),
        .exec_uop_in      (uop),
        .payload_in       (pay),
        .illegal_sel_out  (ill),
        .unit_valid_out   (u_vld),
        .unit_ready_in    (u_rdy),
        .unit_uop_out     (u_uop),
        .unit_payload_out (u_pay),
        .count_out        (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        flush;
        logic        pv;
        logic [3:0]  sel;
        logic [3:0]  uop;
        logic [31:0] pay;
        logic [3:0]  rdy;
        logic        e_prdy;
        logic        e_ill;
        logic [3:0]  e_vld;
        logic [15:0] e_uop;
        logic [31:0] e_pay;
        logic [2:0]  e_cnt;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs [NV];

    function automatic vec_t mk(logic fl, logic pv, logic [3:0] s, logic [3:0] u, logic [31:0] p,
                                logic [3:0] r, logic ep, logic ei, logic [3:0] ev,
                                logic [15:0] eu, logic [31:0] epay, logic [2:0] ec);
        vec_t v;
        v.flush = fl; v.pv = pv; v.sel = s; v.uop = u; v.pay = p; v.rdy = r;
        v.e_prdy = ep; v.e_ill = ei; v.e_vld = ev; v.e_uop = eu; v.e_pay = epay; v.e_cnt = ec;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic fl, input logic pv, input logic [3:0] s, input logic [3:0] u,
                         input logic [31:0] p, input logic [3:0] r);
        @(posedge clk);
        #1;
        flush = fl; push_vld = pv; sel = s; uop = u; pay = p; u_rdy = r;
        @(negedge clk);
    endtask

    task automatic chk_all(input string tag, input logic ep, input logic ei, input logic [3:0] ev,
                           input logic [15:0] eu, input logic [31:0] epay, input logic [2:0] ec);
        chk({tag, ".push_rdy"}, 32'(push_rdy), 32'(ep));
        chk({tag, ".illegal"},  32'(ill),      32'(ei));
        chk({tag, ".valid"},    32'(u_vld),    32'(ev));
        chk({tag, ".uop"},      32'(u_uop),    32'(eu));
        chk({tag, ".payload"},  u_pay,         epay);
        chk({tag, ".count"},    32'(cnt),      32'(ec));
    endtask

    initial begin
        // Expected values describe outputs during the cycle the inputs are applied (before the edge).
        vecs[0]  = mk(0, 0, 4'b0000, 4'h0, 32'h0,    4'b0000, 1, 0, 4'b0000, 16'h0000, 32'h0,    3'd0);
        vecs[1]  = mk(0, 1, LSU_SEL, 4'h5, 32'hCAFE, 4'b0000, 1, 0, 4'b0000, 16'h0000, 32'h0,    3'd0);
        vecs[2]  = mk(0, 0, 4'b0000, 4'h0, 32'h0,    4'b0100, 1, 0, 4'b0100, 16'h0500, 32'hCAFE, 3'd1);
        vecs[3]  = mk(0, 0, 4'b0000, 4'h0, 32'h0,    4'b0000, 1, 0, 4'b0000, 16'h0000, 32'h0,    3'd0);
        vecs[4]  = mk(0, 1, INT_SEL, 4'h1, 32'h11,   4'b0000, 1, 0, 4'b0000, 16'h0000, 32'h0,    3'd0);
        vecs[5]  = mk(0, 1, BRU_SEL, 4'h2, 32'h22,   4'b0000, 1, 0, 4'b0001, 16'h0001, 32'h11,   3'd1);
        vecs[6]  = mk(0, 1, LSU_SEL, 4'h3, 32'h33,   4'b0000, 1, 0, 4'b0001, 16'h0001, 32'h11,   3'd2);
        vecs[7]  = mk(0, 1, VEC_SEL, 4'h4, 32'h44,   4'b0000, 1, 0, 4'b0001, 16'h0001, 32'h11,   3'd3);
        vecs[8]  = mk(0, 1, VEC_SEL, 4'hF, 32'h55,   4'b0000, 0, 0, 4'b0001, 16'h0001, 32'h11,   3'd4);
        vecs[9]  = mk(0, 0, 4'b0000, 4'h0, 32'h0,    4'b1111, 0, 0, 4'b0001, 16'h0001, 32'h11,   3'd4);
        vecs[10] = mk(0, 0, 4'b0000, 4'h0, 32'h0,    4'b1111, 1, 0, 4'b0010, 16'h0020, 32'h22,   3'd3);
        vecs[11] = mk(0, 0, 4'b0000, 4'h0, 32'h0,    4'b1111, 1, 0, 4'b0100, 16'h0300, 32'h33,   3'd2);
        vecs[12] = mk(0, 0, 4'b0000, 4'h0, 32'h0,    4'b1111, 1, 0, 4'b1000, 16'h4000, 32'h44,   3'd1);
        vecs[13] = mk(0, 0, 4'b0000, 4'h0, 32'h0,    4'b1111, 1, 0, 4'b0000, 16'h0000, 32'h0,    3'd0);
        vecs[14] = mk(0, 1, 4'b0011, 4'h6, 32'h66,   4'b1111, 1, 0, 4'b0000, 16'h0000, 32'h0,    3'd0);
        vecs[15] = mk(0, 1, 4'b0000, 4'h7, 32'h77,   4'b1111, 1, 1, 4'b0000, 16'h0000, 32'h0,    3'd0);
        vecs[16] = mk(0, 0, 4'b0000, 4'h0, 32'h0,    4'b1111, 1, 1, 4'b0000, 16'h0000, 32'h0,    3'd0);
        vecs[17] = mk(0, 0, 4'b0000, 4'h0, 32'h0,    4'b1111, 1, 0, 4'b0000, 16'h0000, 32'h0,    3'd0);
        vecs[18] = mk(0, 1, INT_SEL, 4'h8, 32'h88,   4'b1111, 1, 0, 4'b0000, 16'h0000, 32'h0,    3'd0);
        vecs[19] = mk(0, 1, BRU_SEL, 4'h9, 32'h99,   4'b1111, 1, 0, 4'b0001, 16'h0008, 32'h88,   3'd1);
        vecs[20] = mk(0, 0, 4'b0000, 4'h0, 32'h0,    4'b1111, 1, 0, 4'b0010, 16'h0090, 32'h99,   3'd1);
        vecs[21] = mk(0, 0, 4'b0000, 4'h0, 32'h0,    4'b1111, 1, 0, 4'b0000, 16'h0000, 32'h0,    3'd0);

        rst_n = 1'b0; flush = 0; push_vld = 0; sel = '0; uop = '0; pay = '0; u_rdy = '0;
        repeat (3) @(negedge clk);
        chk_all("reset", 1, 0, 4'b0000, 16'h0000, 32'h0, 3'd0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].flush, vecs[i].pv, vecs[i].sel, vecs[i].uop, vecs[i].pay, vecs[i].rdy);
            chk_all($sformatf("vec%0d", i), vecs[i].e_prdy, vecs[i].e_ill, vecs[i].e_vld,
                    vecs[i].e_uop, vecs[i].e_pay, vecs[i].e_cnt);
        end

        // Stalled VEC head blocks a younger INT entry whose unit is free.
        drive(0, 1, VEC_SEL, 4'hA, 32'hAA, 4'b0111);
        drive(0, 1, INT_SEL, 4'hB, 32'hBB, 4'b0111);
        for (int c = 0; c < 10; c++) begin
            drive(0, 0, 4'b0000, 4'h0, 32'h0, 4'b0111);
            chk($sformatf("stall%0d.valid", c), 32'(u_vld), 32'(4'b1000));
            chk($sformatf("stall%0d.count", c), 32'(cnt), 32'd2);
        end
        drive(0, 0, 4'b0000, 4'h0, 32'h0, 4'b1111);
        chk_all("unstall.vec", 1, 0, 4'b1000, 16'hA000, 32'hAA, 3'd2);
        drive(0, 0, 4'b0000, 4'h0, 32'h0, 4'b1111);
        chk_all("unstall.int", 1, 0, 4'b0001, 16'h000B, 32'hBB, 3'd1);
        drive(0, 0, 4'b0000, 4'h0, 32'h0, 4'b1111);
        chk_all("unstall.empty", 1, 0, 4'b0000, 16'h0000, 32'h0, 3'd0);

        // Flush with three queued entries and a same-cycle valid push.
        drive(0, 1, INT_SEL, 4'h1, 32'h1, 4'b0000);
        drive(0, 1, BRU_SEL, 4'h2, 32'h2, 4'b0000);
        drive(0, 1, LSU_SEL, 4'h3, 32'h3, 4'b0000);
        drive(1, 1, VEC_SEL, 4'h4, 32'h4, 4'b0000);
        chk("flush.pre_count", 32'(cnt), 32'd3);
        drive(1, 1, 4'b0011, 4'h5, 32'h5, 4'b0000);
        chk_all("flush.post", 1, 0, 4'b0000, 16'h0000, 32'h0, 3'd0);
        drive(0, 0, 4'b0000, 4'h0, 32'h0, 4'b1111);
        chk_all("flush.absent", 1, 0, 4'b0000, 16'h0000, 32'h0, 3'd0);

        // Asynchronous reset in the middle of issue.
        drive(0, 1, INT_SEL, 4'h1, 32'h101, 4'b0000);
        drive(0, 1, BRU_SEL, 4'h2, 32'h202, 4'b0000);
        drive(0, 0, 4'b0000, 4'h0, 32'h0, 4'b0000);
        chk_all("pre_reset", 1, 0, 4'b0001, 16'h0001, 32'h101, 3'd2);
        u_rdy = 4'b1111;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk_all("async_reset", 1, 0, 4'b0000, 16'h0000, 32'h0, 3'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 1, LSU_SEL, 4'hC, 32'hCC, 4'b0000);
        chk_all("post_reset.push", 1, 0, 4'b0000, 16'h0000, 32'h0, 3'd0);
        drive(0, 0, 4'b0000, 4'h0, 32'h0, 4'b0100);
        chk_all("post_reset.issue", 1, 0, 4'b0100, 16'h0C00, 32'hCC, 3'd1);
        drive(0, 0, 4'b0000, 4'h0, 32'h0, 4'b0000);
        chk_all("post_reset.done", 1, 0, 4'b0000, 16'h0000, 32'h0, 3'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/issue_queue.md
# issue_queue

Parametrised in-order issue stage placed between decode and the execution units. It buffers decoded micro-ops in a DEPTH-entry FIFO. Each head entry is steered to exactly one of NUM_UNITS execution units, selected by a one-hot unit-select field, and retires on a valid/ready handshake with that unit. New over the plain combinational steering stage: back-pressure, buffering, flush, and rejection of illegal selects.

## Interface
Parameters:
- NUM_UNITS, 4: number of execution units. Bit i of the select field maps to unit i.
- DEPTH, 4: FIFO entries. Power of two, at least 2.
- UOP_W, 4: micro-op width.
- PAYLOAD_W, 32: per-entry payload width (operands/tags), forwarded unchanged.

Ports:
- clock_in  input  1  clock. Everything is rising-edge.
- reset_n_in  input  1  asynchronous, active-low reset.
- flush_in  input  1  synchronous flush of all queued entries.
- push_valid_in  input  1  decode offers an entry.
- push_ready_out  output  1  queue can accept an entry.
- exec_unit_sel_in  input  NUM_UNITS  one-hot target unit.
- exec_uop_in  input  UOP_W  micro-op.
- payload_in  input  PAYLOAD_W  payload.
- illegal_sel_out  output  1  one-cycle pulse: an offered entry was rejected.
- unit_valid_out  output  NUM_UNITS  per-unit enable; at most one bit set.
- unit_ready_in  input  NUM_UNITS  per-unit accept.
- unit_uop_out  output  NUM_UNITS*UOP_W  per-unit micro-op, unit i at bits [i*UOP_W +: UOP_W].
- unit_payload_out  output  PAYLOAD_W  head payload, shared by all units.
- count_out  output  $clog2(DEPTH+1)  occupancy.

## Operation
- **Push:** an entry is accepted when push_valid_in && push_ready_out && exec_unit_sel_in is one-hot && !flush_in. It is written at wr_ptr, then wr_ptr advances.
- **Illegal select:** push_valid_in && push_ready_out with exec_unit_sel_in zero or multi-hot.
  - The entry is not written.
  - illegal_sel_out is 1 in the next cycle (registered).
  - The handshake still completes, so decode must not re-offer the entry.
- **push_ready_out** = (count < DEPTH). It does not depend on unit_ready_in; there is no full-queue pass-through.
- **Issue:** while the queue is non-empty:
  - unit_valid_out = the head's select field.
  - The selected lane of unit_uop_out carries the head micro-op; every other lane is 4'b0000 (generally, UOP_W zeros).
  - unit_payload_out = head payload.
- **Empty queue:** all unit_valid_out bits are 0, all uop lanes are 0, and unit_payload_out is 0.
- **Pop:** the head pops when (unit_valid_out & unit_ready_in) != 0, then rd_ptr advances. Issue is strictly in order, so a stalled head blocks younger entries even when they target free units.
- **Occupancy:** count increments on push only, decrements on pop only, and is unchanged when push and pop happen in the same cycle.
- **Pointers:** wrap modulo DEPTH.
- **Flush:** flush_in = 1 in a cycle means the next cycle has count = 0, both pointers = 0 and illegal_sel_out = 0. Flush overrides a same-cycle push and pop, and a pop in the flush cycle still counts as accepted by the unit.
- **Reset** (asynchronous, reset_n_in = 0) puts every output in this state immediately:
  - pointers and count_out = 0;
  - push_ready_out = 1;
  - illegal_sel_out = 0;
  - unit_valid_out = 0;
  - uop lanes = 0;
  - unit_payload_out = 0.
- **FIFO storage** is not reset. The outputs are gated by the empty condition, so stale storage is never visible.

## Timing
- An entry pushed in cycle N is visible on the unit outputs in cycle N+1 at the earliest. There is no same-cycle bypass.
- With unit_ready_in held high, throughput is one issue per cycle.
- Combinational paths:
  - unit_ready_in → pop → next-state only. It never reaches push_ready_out or unit_valid_out in the same cycle.
  - All unit outputs decode from registered head and count.
- Boundary cases:
  - Full queue with push_valid_in high: no write; count stays at DEPTH.
  - Full queue with a pop: push_ready_out rises in the next cycle.
  - Single entry, pushed and popped in the same cycle: a valid push is still accepted and count is unchanged.
  - Empty queue with push: count becomes 1. No pop can occur while empty.
  - Reset asserted mid-transfer: the entry is lost. Downstream units must ignore any handshake completed in the reset cycle.

## Structure
- Package core101_issue_pkg holds:
  - unit index constants INT_UNIT = 0, BRU_UNIT = 1, LSU_UNIT = 2, VEC_UNIT = 3;
  - the matching one-hot select constants 4'b0001, 4'b0010, 4'b0100, 4'b1000;
  - a one-hot check function.
- Sub-module issue_fifo holds:
  - parameters WIDTH and DEPTH;
  - the storage, pointers, count and flush logic.
- issue_queue contains:
  - the legality check;
  - the illegal-pulse register;
  - per-unit steering/zeroing of the uop lanes;
  - the pop generation.

## Test plan
All tests use the default parameters.
- Reset, then push LSU (4'b0100) with uop 4'h5 and payload 32'hCAFE. Next cycle: unit_valid_out = 4'b0100, lane 2 = 4'h5, other lanes 0. With unit_ready_in[2] = 1, count returns to 0.
- Push 4 entries (INT, BRU, LSU, VEC) while unit_ready_in = 0:
  - push_ready_out falls after the 4th push and a 5th push is not accepted;
  - raising unit_ready_in = 4'b1111 then issues INT, BRU, LSU, VEC in consecutive cycles.
- Head targets VEC with unit_ready_in = 4'b0111:
  - the head stays for 10 cycles and the younger INT entry does not issue;
  - on the first cycle after unit_ready_in[3] rises, VEC issues, followed by INT.
- Offer exec_unit_sel_in = 4'b0011, then 4'b0000: illegal_sel_out pulses twice, count stays 0 and no unit_valid_out bit rises.
- Queue holds 3 entries; assert flush_in together with a valid push. Next cycle: count = 0, all unit_valid_out bits = 0, and the pushed entry is absent.
- Assert reset_n_in low asynchronously mid-issue with count = 2: outputs clear immediately. After release, a fresh push issues normally.
